// File: rtl/br_resolve_pkg.sv
// Shared types and constants for the EX-stage branch resolution slice.
package br_resolve_pkg;

  localparam int unsigned BR_WD        = 33;
  localparam int unsigned STALL_W      = 6;
  localparam int unsigned EX_STALL_BIT = 3;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BEQ,
    BNE,
    BGEZ,
    BGTZ,
    BLEZ,
    BLTZ,
    BGEZAL,
    BLTZAL,
    J,
    JAL,
    JR,
    JALR
  } br_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StDone
  } br_state_e;

  // Word offset of a B-type branch, sign-extended and scaled to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/br_resolve_if.sv
// EX-side branch operands, the incoming prediction and the redirect/training bus.
interface br_resolve_if;
  import br_resolve_pkg::*;

  logic              ex_valid;
  logic [31:0]       ex_pc;
  br_op_e            br_op;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic [15:0]       imm16;
  logic [25:0]       instr_index;
  logic              ds_in_id;
  logic [BR_WD-1:0]  bp_to_ex_bus;
  logic [BR_WD-1:0]  br_bus;
  logic              br_pending;

  modport master (
    output ex_valid, ex_pc, br_op, rs_data, rt_data, imm16, instr_index, ds_in_id,
    output bp_to_ex_bus,
    input  br_bus, br_pending
  );

  modport slave (
    input  ex_valid, ex_pc, br_op, rs_data, rt_data, imm16, instr_index, ds_in_id,
    input  bp_to_ex_bus,
    output br_bus, br_pending
  );

endinterface

// File: rtl/br_resolve_eval.sv
// Combinational branch evaluator: actual direction, actual target and correct next PC.
module br_eval
  import br_resolve_pkg::*;
(
  input  br_op_e      br_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] ex_pc,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        rs_zero;

  assign pc_plus4 = ex_pc + 32'd4;
  assign pc_plus8 = ex_pc + 32'd8;
  assign rs_zero  = (rs == 32'd0);

  always_comb begin
    taken  = 1'b0;
    target = pc_plus4 + br_offset(imm16);
    case (br_op)
      BEQ:            taken = (rs == rt);
      BNE:            taken = (rs != rt);
      BGEZ, BGEZAL:   taken = ~rs[31];
      BLTZ, BLTZAL:   taken = rs[31];
      BGTZ:           taken = ~rs[31] & ~rs_zero;
      BLEZ:           taken = rs[31] | rs_zero;
      J, JAL: begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], instr_index, 2'b00};
      end
      JR, JALR: begin
        taken  = 1'b1;
        target = rs;
      end
      default:        taken = 1'b0;
    endcase
  end

  assign next_pc = taken ? target : pc_plus8;

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: compares actual outcome with the prediction, issues one redirect per
// branch once its delay slot is in ID, and counts branches and redirects.
module br_resolve
  import br_resolve_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  br_resolve_if.slave        bus,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  logic        taken;
  logic [31:0] target;
  logic [31:0] next_pc;

  br_eval u_eval (
    .br_op       (bus.br_op),
    .rs          (bus.rs_data),
    .rt          (bus.rt_data),
    .imm16       (bus.imm16),
    .instr_index (bus.instr_index),
    .ex_pc       (bus.ex_pc),
    .taken       (taken),
    .target      (target),
    .next_pc     (next_pc)
  );

  br_state_e   state_q;
  logic        pending_q;
  logic [31:0] hold_target_q;

  logic        pred_e;
  logic [31:0] pred_target;
  logic        is_br;
  logic        mis;
  logic        ex_hold;
  logic        fire;
  logic [31:0] fire_target;
  logic        unused_stall;

  assign pred_e       = bus.bp_to_ex_bus[BR_WD-1];
  assign pred_target  = bus.bp_to_ex_bus[31:0];
  assign is_br        = bus.ex_valid && (bus.br_op != BR_NONE);
  assign mis          = is_br && ((taken != pred_e) || (taken && (target != pred_target)));
  assign ex_hold      = (stall[EX_STALL_BIT] == Stop);
  assign unused_stall = ^{stall[STALL_W-1:EX_STALL_BIT+1], stall[EX_STALL_BIT-1:0]};

  // Redirect is combinational so a branch with its delay slot present redirects at once.
  always_comb begin
    fire        = 1'b0;
    fire_target = next_pc;
    if (!rst && !flush) begin
      case (state_q)
        StIdle:  fire = mis && bus.ds_in_id;
        StHold: begin
          fire        = bus.ds_in_id;
          fire_target = hold_target_q;
        end
        default: fire = 1'b0;
      endcase
    end
  end

  assign bus.br_bus     = {fire, fire ? fire_target : 32'd0};
  assign bus.br_pending = pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      hold_target_q <= 32'd0;
      br_cnt        <= '0;
      mispred_cnt   <= '0;
    end else begin
      if (fire) mispred_cnt <= mispred_cnt + 1'b1;
      if (is_br && !ex_hold && !flush) br_cnt <= br_cnt + 1'b1;

      if (flush) begin
        state_q   <= StIdle;
        pending_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (mis) begin
              if (!bus.ds_in_id) begin
                state_q       <= StHold;
                pending_q     <= 1'b1;
                hold_target_q <= next_pc;
              end else if (ex_hold) begin
                state_q <= StDone;
              end
            end
          end
          StHold: begin
            if (bus.ds_in_id) begin
              pending_q <= 1'b0;
              state_q   <= ex_hold ? StDone : StIdle;
            end
          end
          StDone: begin
            // The fired branch is still in EX; wait for it to leave without refiring.
            if (!ex_hold) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: single-cycle vector table plus hold/stall/flush/reset sequences.
module tb_br_resolve;
  import br_resolve_pkg::*;

  typedef struct {
    logic        valid;
    br_op_e      op;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [25:0] idx;
    logic        pe;
    logic [31:0] pt;
    logic        exp_e;
    logic [31:0] exp_t;
  } vec_t;

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        br_cnt;
  logic [31:0]        mispred_cnt;

  int n_tests;
  int n_fail;
  int pulses;
  int exp_br;
  int exp_mis;
  int p0;

  br_resolve_if bif ();

  br_resolve #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .bus         (bif),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bif.br_bus[32] === 1'b1) pulses <= pulses + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input br_op_e op, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                       input logic [25:0] idx, input logic pe, input logic [31:0] pt,
                       input logic ds);
    bif.ex_valid     = valid;
    bif.br_op        = op;
    bif.ex_pc        = pc;
    bif.rs_data      = rs;
    bif.rt_data      = rt;
    bif.imm16        = imm;
    bif.instr_index  = idx;
    bif.bp_to_ex_bus = {pe, pt};
    bif.ds_in_id     = ds;
  endtask

  function automatic vec_t mk(input logic v, input br_op_e op, input logic [31:0] pc,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] imm, input logic [25:0] idx, input logic pe,
                              input logic [31:0] pt, input logic ee, input logic [31:0] et);
    vec_t r;
    r.valid = v; r.op = op; r.pc = pc; r.rs = rs; r.rt = rt; r.imm = imm; r.idx = idx;
    r.pe = pe; r.pt = pt; r.exp_e = ee; r.exp_t = et;
    return r;
  endfunction

  vec_t vecs[15];

  initial begin
    n_tests = 0; n_fail = 0; pulses = 0; exp_br = 0; exp_mis = 0;
    vecs[0]  = mk(1, BEQ,    32'h0040_0100, 32'd5, 32'd5, 16'h0010, 26'd0, 0, 32'd0,
                  1, 32'h0040_0144);
    vecs[1]  = mk(1, BNE,    32'h0040_0200, 32'd7, 32'd7, 16'h0020, 26'd0, 1, 32'h0040_0300,
                  1, 32'h0040_0208);
    vecs[2]  = mk(1, JR,     32'h0040_0000, 32'h8000_1000, 32'd0, 16'h0, 26'd0, 1,
                  32'h8000_1000, 0, 32'd0);
    vecs[3]  = mk(1, BGEZ,   32'h0040_1000, 32'd0, 32'd0, 16'hFFFF, 26'd0, 0, 32'd0,
                  1, 32'h0040_1000);
    vecs[4]  = mk(1, BLTZ,   32'h0040_1000, 32'd1, 32'd0, 16'h0008, 26'd0, 1, 32'h0040_1024,
                  1, 32'h0040_1008);
    vecs[5]  = mk(1, BLEZ,   32'h0040_2000, 32'd0, 32'd0, 16'h0004, 26'd0, 1, 32'h0040_2014,
                  0, 32'd0);
    vecs[6]  = mk(1, BGTZ,   32'h0040_2000, 32'd0, 32'd0, 16'h0004, 26'd0, 0, 32'd0,
                  0, 32'd0);
    vecs[7]  = mk(1, J,      32'h1000_0000, 32'd0, 32'd0, 16'h0, 26'h000_0100, 1,
                  32'h1000_0000, 1, 32'h1000_0400);
    vecs[8]  = mk(1, JAL,    32'hF000_0FFC, 32'd0, 32'd0, 16'h0, 26'h3FF_FFFF, 0, 32'd0,
                  1, 32'hFFFF_FFFC);
    vecs[9]  = mk(1, JALR,   32'h0040_0010, 32'h0040_0080, 32'd0, 16'h0, 26'd0, 1,
                  32'h0040_0084, 1, 32'h0040_0080);
    vecs[10] = mk(1, BLTZAL, 32'h0040_0000, 32'h8000_0000, 32'd0, 16'h8000, 26'd0, 0, 32'd0,
                  1, 32'h003E_0004);
    vecs[11] = mk(1, BGEZAL, 32'h0040_0000, 32'hFFFF_FFFF, 32'd0, 16'h0010, 26'd0, 0, 32'd0,
                  0, 32'd0);
    vecs[12] = mk(1, BEQ,    32'hFFFF_FFF8, 32'd9, 32'd9, 16'h0001, 26'd0, 0, 32'd0,
                  1, 32'h0000_0000);
    vecs[13] = mk(1, BR_NONE, 32'h0040_0000, 32'd1, 32'd2, 16'h0010, 26'd0, 1, 32'h1234_5678,
                  0, 32'd0);
    vecs[14] = mk(0, BNE,    32'h0040_0000, 32'd1, 32'd2, 16'h0010, 26'd0, 0, 32'd0,
                  0, 32'd0);

    rst = 1'b1; stall = '0; flush = 1'b0;
    drive(0, BR_NONE, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 32'd0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_br_bus", 64'(bif.br_bus), 64'd0);
    chk("reset_pending", 64'(bif.br_pending), 64'd0);
    chk("reset_br_cnt", 64'(br_cnt), 64'd0);
    chk("reset_mispred_cnt", 64'(mispred_cnt), 64'd0);
    rst = 1'b0;

    // Single-cycle resolves with the delay slot present and EX advancing.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].op, vecs[i].pc, vecs[i].rs, vecs[i].rt, vecs[i].imm,
            vecs[i].idx, vecs[i].pe, vecs[i].pt, 1'b1);
      #1;
      chk($sformatf("vec%0d_br_bus", i), 64'(bif.br_bus), 64'({vecs[i].exp_e, vecs[i].exp_t}));
      if (vecs[i].valid && vecs[i].op != BR_NONE) exp_br++;
      if (vecs[i].exp_e) exp_mis++;
    end
    @(negedge clk);
    drive(0, BR_NONE, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 32'd0, 0);
    #1;
    chk("table_br_cnt", 64'(br_cnt), 64'(exp_br));
    chk("table_mispred_cnt", 64'(mispred_cnt), 64'(exp_mis));

    // HOLD: taken BGTZ mispredicted with no delay slot for three cycles.
    @(negedge clk);
    drive(1, BGTZ, 32'h0040_3000, 32'd1, 32'd0, 16'h0010, 26'd0, 0, 32'd0, 0);
    exp_br++;
    #1;
    chk("hold_resolve_br_bus", 64'(bif.br_bus), 64'd0);
    chk("hold_resolve_pending", 64'(bif.br_pending), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(0, BGTZ, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0, 16'h0100, 26'd0, 0, 32'd0, 0);
      #1;
      chk($sformatf("hold_wait%0d_pending", c), 64'(bif.br_pending), 64'd1);
      chk($sformatf("hold_wait%0d_br_bus", c), 64'(bif.br_bus), 64'd0);
    end
    @(negedge clk);
    bif.ds_in_id = 1'b1;
    #1;
    chk("hold_fire_br_bus", 64'(bif.br_bus), 64'({1'b1, 32'h0040_3044}));
    chk("hold_fire_pending", 64'(bif.br_pending), 64'd1);
    exp_mis++;
    @(negedge clk);
    #1;
    chk("hold_after_br_bus", 64'(bif.br_bus), 64'd0);
    chk("hold_after_pending", 64'(bif.br_pending), 64'd0);

    // EX held for four cycles across a same-cycle mispredict: exactly one pulse.
    @(negedge clk);
    stall[EX_STALL_BIT] = Stop;
    drive(1, BEQ, 32'h0040_4000, 32'd3, 32'd3, 16'h0002, 26'd0, 0, 32'd0, 1);
    p0 = pulses;
    #1;
    chk("stall_fire_br_bus", 64'(bif.br_bus), 64'({1'b1, 32'h0040_400C}));
    exp_mis++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall_done%0d_br_bus", c), 64'(bif.br_bus), 64'd0);
    end
    @(negedge clk);
    stall[EX_STALL_BIT] = NoStop;
    exp_br++;
    #1;
    chk("stall_release_br_bus", 64'(bif.br_bus), 64'd0);
    @(negedge clk);
    drive(1, BNE, 32'h0040_5000, 32'd1, 32'd1, 16'h0010, 26'd0, 1, 32'd0, 1);
    exp_br++;
    exp_mis++;
    #1;
    chk("stall_pulses", 64'(pulses - p0), 64'd1);
    chk("post_stall_fire_br_bus", 64'(bif.br_bus), 64'({1'b1, 32'h0040_5008}));
    @(negedge clk);
    drive(0, BR_NONE, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 32'd0, 0);
    #1;
    chk("stall_br_cnt", 64'(br_cnt), 64'(exp_br));
    chk("stall_mispred_cnt", 64'(mispred_cnt), 64'(exp_mis));

    // Flush arriving with ds_in_id drops the pending redirect.
    @(negedge clk);
    drive(1, BEQ, 32'h0040_6000, 32'd4, 32'd4, 16'h0000, 26'd0, 0, 32'd0, 0);
    exp_br++;
    @(negedge clk);
    drive(0, BR_NONE, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 32'd0, 1);
    flush = 1'b1;
    #1;
    chk("flush_br_bus", 64'(bif.br_bus), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_after_pending", 64'(bif.br_pending), 64'd0);
    chk("flush_after_br_bus", 64'(bif.br_bus), 64'd0);
    chk("flush_br_cnt", 64'(br_cnt), 64'(exp_br));
    chk("flush_mispred_cnt", 64'(mispred_cnt), 64'(exp_mis));

    // Reset in the middle of HOLD.
    @(negedge clk);
    drive(1, BNE, 32'h0040_7000, 32'd1, 32'd2, 16'h0004, 26'd0, 0, 32'd0, 0);
    @(negedge clk);
    drive(0, BR_NONE, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0, 0, 32'd0, 0);
    #1;
    chk("rst_hold_pending", 64'(bif.br_pending), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bif.ds_in_id = 1'b1;
    #1;
    chk("rst_cycle_br_bus", 64'(bif.br_bus), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_after_br_bus", 64'(bif.br_bus), 64'd0);
    chk("rst_after_pending", 64'(bif.br_pending), 64'd0);
    chk("rst_after_br_cnt", 64'(br_cnt), 64'd0);
    chk("rst_after_mispred_cnt", 64'(mispred_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
